// File: rtl/qhttp_pauli_sequencer_pkg.sv
// Shared types and constants for the Pauli correction sequencer.
// Optional macro QHTTP_VIRTUAL_Z_EN is consumed by the top, not here.
package qhttp_pkg;

  localparam int NUM_QUBITS = 4;

  // Bit positions inside the 4-bit correction nibble.
  localparam int X_BIT   = 0;
  localparam int Z_BIT   = 1;
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 3;

  typedef enum logic [2:0] {
    IDLE,
    X_PULSE,
    X_SETTLE,
    Z_PULSE,
    Z_SETTLE,
    DONE
  } state_e;

  typedef struct packed {
    logic [IDX_MSB-IDX_LSB:0] idx;
    logic                     z;
    logic                     x;
  } correction_t;

  function automatic logic [NUM_QUBITS-1:0] qubit_onehot(input logic [IDX_MSB-IDX_LSB:0] idx);
    return NUM_QUBITS'(1) << idx;
  endfunction

endpackage

// File: rtl/qhttp_pauli_sequencer_if.sv
// Quantum correction handshake between the QCI handshake stage (master)
// and the Pauli sequencer (slave).
interface qhttp_pauli_sequencer_if;

  logic [3:0] quantum_correction;
  logic       quantum_valid;
  logic       quantum_ready;

  modport master (
    output quantum_correction,
    output quantum_valid,
    input  quantum_ready
  );

  modport slave (
    input  quantum_correction,
    input  quantum_valid,
    output quantum_ready
  );

endinterface

// File: rtl/qhttp_pauli_sequencer_pulse_timer.sv
// Loadable 8-bit down-counter shared by pulse and settle phases.
// o_done is high while the count sits at zero; a load of N gives N+1 cycles.
module qhttp_pulse_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_done
);

  logic [7:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_done = (r_count == 8'd0);

endmodule

// File: rtl/qhttp_pauli_sequencer.sv
// Expands one Pauli correction into timed X/Z drive pulses on one of four qubits.
// Macro QHTTP_VIRTUAL_Z_EN: Z is tracked in pauli_frame instead of being pulsed.
module qhttp_pauli_sequencer
  import qhttp_pkg::*;
#(
  parameter int PULSE_CYCLES  = 20,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  qhttp_pauli_sequencer_if.slave  q,
  input  logic                    abort,
  output logic [NUM_QUBITS-1:0]   x_drive,
  output logic [NUM_QUBITS-1:0]   z_drive,
  output logic                    busy,
  output logic [CNT_W-1:0]        applied_count,
  output logic [7:0]              pauli_frame
);

`ifdef QHTTP_VIRTUAL_Z_EN
  localparam bit VIRTUAL_Z = 1'b1;
`else
  localparam bit VIRTUAL_Z = 1'b0;
`endif

  localparam bit         HAS_SETTLE  = (SETTLE_CYCLES != 0);
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = HAS_SETTLE ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  state_e                r_state;
  state_e                w_next_state;
  state_e                w_after_x;
  correction_t           r_corr;
  correction_t           w_in;
  correction_t           w_cur;
  logic                  r_ready;
  logic                  r_busy;
  logic [NUM_QUBITS-1:0] r_x_drive;
  logic [NUM_QUBITS-1:0] r_z_drive;
  logic [CNT_W-1:0]      r_count;
  logic                  w_accept;
  logic                  w_aborting;
  logic                  w_complete;
  logic                  w_load;
  logic [7:0]            w_load_val;
  logic                  w_timer_done;

  assign w_in     = correction_t'(q.quantum_correction);
  assign w_accept = (r_state == IDLE) && r_ready && q.quantum_valid;
  // Drives for the cycle after an accept must use the incoming nibble, not the stale latch.
  assign w_cur     = w_accept ? w_in : r_corr;
  assign w_after_x = (r_corr.z && !VIRTUAL_Z) ? Z_PULSE : DONE;

  qhttp_pulse_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_aborting   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in.x)                       w_next_state = X_PULSE;
          else if (w_in.z && !VIRTUAL_Z)    w_next_state = Z_PULSE;
          else                              w_next_state = DONE;
        end
      end
      X_PULSE:  if (w_timer_done) w_next_state = HAS_SETTLE ? X_SETTLE : w_after_x;
      X_SETTLE: if (w_timer_done) w_next_state = w_after_x;
      Z_PULSE:  if (w_timer_done) w_next_state = HAS_SETTLE ? Z_SETTLE : DONE;
      Z_SETTLE: if (w_timer_done) w_next_state = DONE;
      DONE:     if (!q.quantum_valid) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase

    // Abort only matters while a correction is actively being driven or settled.
    if (abort && (r_state != IDLE) && (r_state != DONE)) begin
      w_next_state = DONE;
      w_aborting   = 1'b1;
    end
  end

  assign w_complete = (w_next_state == DONE) && (r_state != DONE) && !w_aborting;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = PULSE_LOAD;
    if (w_next_state != r_state) begin
      case (w_next_state)
        X_PULSE, Z_PULSE: w_load = 1'b1;
        X_SETTLE, Z_SETTLE: begin
          w_load     = 1'b1;
          w_load_val = SETTLE_LOAD;
        end
        default: w_load = 1'b0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_corr    <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_x_drive <= '0;
      r_z_drive <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_ready   <= (w_next_state == IDLE);
      r_busy    <= (w_next_state != IDLE);
      r_x_drive <= (w_next_state == X_PULSE) ? qubit_onehot(w_cur.idx) : '0;
      r_z_drive <= (w_next_state == Z_PULSE) ? qubit_onehot(w_cur.idx) : '0;
      if (w_accept) begin
        r_corr <= w_in;
      end
      if (w_complete && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef QHTTP_VIRTUAL_Z_EN
  logic [7:0] r_frame;
  logic [7:0] w_frame_flip;

  always_comb begin
    w_frame_flip = 8'h00;
    if (w_complete) begin
      w_frame_flip[{w_cur.idx, 1'b0}] = w_cur.x;
      w_frame_flip[{w_cur.idx, 1'b1}] = w_cur.z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= 8'h00;
    end else begin
      r_frame <= r_frame ^ w_frame_flip;
    end
  end

  assign pauli_frame = r_frame;
`else
  assign pauli_frame = 8'h00;
`endif

  assign q.quantum_ready = r_ready;
  assign busy            = r_busy;
  assign x_drive         = r_x_drive;
  assign z_drive         = r_z_drive;
  assign applied_count   = r_count;

endmodule

// File: tb/tb_qhttp_pauli_sequencer.sv
// Self-checking bench: two sequencer instances (default timing, and a 1-cycle pulse /
// no-settle / 3-bit counter build) share stimulus and are compared to a timeline model.
`timescale 1ns/1ps
module tb_qhttp_pauli_sequencer;

  localparam int P0 = 20;
  localparam int S0 = 8;
  localparam int P1 = 1;
  localparam int S1 = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] corr  = 4'h0;
  logic       valid = 1'b0;
  logic       abort = 1'b0;

  qhttp_pauli_sequencer_if if0 ();
  qhttp_pauli_sequencer_if if1 ();
  assign if0.quantum_correction = corr;
  assign if0.quantum_valid      = valid;
  assign if1.quantum_correction = corr;
  assign if1.quantum_valid      = valid;

  logic [3:0]  x0, z0, x1, z1;
  logic        busy0, busy1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic [7:0]  pf0, pf1;

  qhttp_pauli_sequencer #(.PULSE_CYCLES(P0), .SETTLE_CYCLES(S0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .q(if0), .abort(abort), .x_drive(x0), .z_drive(z0),
    .busy(busy0), .applied_count(cnt0), .pauli_frame(pf0));

  qhttp_pauli_sequencer #(.PULSE_CYCLES(P1), .SETTLE_CYCLES(S1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .q(if1), .abort(abort), .x_drive(x1), .z_drive(z1),
    .busy(busy1), .applied_count(cnt1), .pauli_frame(pf1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model: per-transaction timeline ----------------
  // mode 0 = waiting for a correction, 1 = timeline running, 2 = completed/aborted, awaiting valid low
  int         m_mode [2]  = '{0, 0};
  int         m_e    [2]  = '{0, 0};
  int         m_cnt  [2]  = '{0, 0};
  logic [3:0] m_corr [2]  = '{4'h0, 4'h0};
  logic [7:0] m_frame[2]  = '{8'h00, 8'h00};
  int         m_max  [2]  = '{65535, 7};
  int         m_p    [2]  = '{P0, P1};
  int         m_s    [2]  = '{S0, S1};

  function automatic bit z_physical();
`ifdef QHTTP_VIRTUAL_Z_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int txn_len(input logic [3:0] c, input int p, input int s);
    return (c[0] ? p + s : 0) + ((c[1] && z_physical()) ? p + s : 0);
  endfunction

  // Returns {z_drive, x_drive} expected e cycles into the timeline.
  function automatic logic [7:0] exp_drive(input logic [3:0] c, input int e, input int p, input int s);
    int         t;
    logic [3:0] oh;
    t  = e;
    oh = 4'b0001 << c[3:2];
    if (c[0]) begin
      if (t < p) return {4'h0, oh};
      if (t < p + s) return 8'h00;
      t = t - (p + s);
    end
    if (c[1] && z_physical() && (t < p)) return {oh, 4'h0};
    return 8'h00;
  endfunction

  task automatic model_finish(input int d);
    m_mode[d] = 2;
    if (m_cnt[d] < m_max[d]) m_cnt[d]++;
`ifdef QHTTP_VIRTUAL_Z_EN
    if (m_corr[d][0]) m_frame[d][2*m_corr[d][3:2]]     = ~m_frame[d][2*m_corr[d][3:2]];
    if (m_corr[d][1]) m_frame[d][2*m_corr[d][3:2] + 1] = ~m_frame[d][2*m_corr[d][3:2] + 1];
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_e[d] = 0; m_cnt[d] = 0; m_frame[d] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_mode[d])
          0: if (valid) begin
            m_corr[d] = corr;
            m_e[d]    = 0;
            if (txn_len(corr, m_p[d], m_s[d]) == 0) model_finish(d);
            else m_mode[d] = 1;
          end
          1: if (abort) m_mode[d] = 2;
             else begin
               m_e[d]++;
               if (m_e[d] >= txn_len(m_corr[d], m_p[d], m_s[d])) model_finish(d);
             end
          default: if (!valid) m_mode[d] = 0;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [7:0] e0, e1;
    e0 = (m_mode[0] == 1) ? exp_drive(m_corr[0], m_e[0], P0, S0) : 8'h00;
    e1 = (m_mode[1] == 1) ? exp_drive(m_corr[1], m_e[1], P1, S1) : 8'h00;
    check("x_drive0", x0, e0[3:0]);
    check("z_drive0", z0, e0[7:4]);
    check("ready0", if0.quantum_ready, m_mode[0] == 0);
    check("busy0", busy0, m_mode[0] != 0);
    check("count0", cnt0, m_cnt[0]);
    check("frame0", pf0, m_frame[0]);
    check("onehot0", $countones({z0, x0}) <= 1, 1);
    check("x_drive1", x1, e1[3:0]);
    check("z_drive1", z1, e1[7:4]);
    check("ready1", if1.quantum_ready, m_mode[1] == 0);
    check("busy1", busy1, m_mode[1] != 0);
    check("count1", cnt1, m_cnt[1]);
    check("frame1", pf1, m_frame[1]);
  end

  // ---------------- per-transaction activity monitor (dut0) ----------------
  bit         mon_en = 1'b0;
  int         n_busy0, n_x0, n_z0;
  logic [3:0] or_x0, or_z0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy0) n_busy0++;
      if (x0 != 4'h0) n_x0++;
      if (z0 != 4'h0) n_z0++;
      or_x0 = or_x0 | x0;
      or_z0 = or_z0 | z0;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(if0.quantum_ready && if1.quantum_ready)) begin
      @(negedge clk);
      t++;
      if (t > 300) begin timeout("wait_idle"); break; end
    end
  endtask

  // hold: extra cycles valid stays high after ready is seen low.
  // abort_at: cycle index (0 = first busy cycle) to pulse abort; -2 = with the accept; -1 = never.
  task automatic send(input logic [3:0] c, input int hold, input int abort_at);
    int t;
    wait_idle();
    @(negedge clk);
    n_busy0 = 0; n_x0 = 0; n_z0 = 0; or_x0 = 4'h0; or_z0 = 4'h0;
    mon_en = 1'b1;
    corr   = c;
    valid  = 1'b1;
    abort  = (abort_at == -2);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((if0.quantum_ready || if1.quantum_ready) && t < 10);
    if (t >= 10) timeout("accept");
    t = 0;
    forever begin
      valid = (t < hold);
      abort = (t == abort_at);
      @(negedge clk);
      t++;
      if (if0.quantum_ready && if1.quantum_ready && !valid) break;
      if (t > 400) begin timeout("txn_end"); break; end
    end
    abort  = 1'b0;
    valid  = 1'b0;
    mon_en = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_ready", if0.quantum_ready, 1);
    check("rst_busy", busy0, 0);
    check("rst_drives", {z0, x0}, 0);
    check("rst_count", cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // X on qubit 1
    send(4'b0101, 0, -1);
    check("t1_x_cycles", n_x0, 20);
    check("t1_x_bits", or_x0, 4'b0010);
    check("t1_z_bits", or_z0, 4'b0000);
    check("t1_busy_cycles", n_busy0, 29);
    check("t1_count", cnt0, 1);

    // Y on qubit 3
    send(4'b1111, 0, -1);
    check("t2_x_cycles", n_x0, 20);
    check("t2_x_bits", or_x0, 4'b1000);
`ifdef QHTTP_VIRTUAL_Z_EN
    check("t2_z_bits", or_z0, 4'b0000);
    check("t2_frame", pf0, 8'b1100_0000);
    check("t2_busy_cycles", n_busy0, 29);
`else
    check("t2_z_cycles", n_z0, 20);
    check("t2_z_bits", or_z0, 4'b1000);
    check("t2_frame", pf0, 8'h00);
    check("t2_busy_cycles", n_busy0, 57);
`endif
    check("t2_count", cnt0, 2);

    // identity
    send(4'b0000, 0, -1);
    check("t3_drives", {or_z0, or_x0}, 0);
    check("t3_busy_cycles", n_busy0, 1);
    check("t3_count", cnt0, 3);

    // abort in the same cycle as accept: accept wins
    send(4'b0001, 0, -2);
    check("t3b_x_cycles", n_x0, 20);
    check("t3b_count", cnt0, 4);

    // abort on the 5th X_PULSE cycle, valid held through
    send(4'b0101, 20, 4);
    check("t4_x_cycles", n_x0, 5);
    check("t4_count", cnt0, 4);

    // valid held 10 cycles past DONE
    send(4'b0001, 38, -1);
    check("t5_busy_cycles", n_busy0, 39);
    check("t5_count", cnt0, 5);

    // async reset in the middle of a Z pulse on qubit 1
    wait_idle();
    @(negedge clk);
    corr  = 4'b0110;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
`ifndef QHTTP_VIRTUAL_Z_EN
    check("t6_z_before_rst", z0, 4'b0010);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_drives", {z0, x0}, 0);
    check("t6_rst_ready", if0.quantum_ready, 1);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_count", cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b0101, 0, -1);
    check("t6_after_x_bits", or_x0, 4'b0010);
    check("t6_after_count", cnt0, 1);

    // randomized corrections, holds and aborts
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rc;
      int         rh, ra;
      rc = 4'($urandom);
      rh = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      send(rc, rh, ra);
    end

    // the 3-bit counter instance must saturate
    for (int i = 0; i < 8; i++) send(4'b0000, 0, -1);
    check("sat_count1", cnt1, 3'h7);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
